// File: rtl/uart_pkg.sv
// Shared definitions for the FIFO-draining UART transmitter.
//   tx_state_t : transmitter FSM states
//   DATA_BITS  : payload bits per 8N1 frame
package uart_pkg;

  localparam int unsigned DATA_BITS = 8;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    START,
    DATA,
    STOP
  } tx_state_t;

endpackage

// File: rtl/uart_baud_counter.sv
// Bit-period timer for the UART transmitter.
// Counts 0..CLKS_PER_BIT-1 and wraps; bit_done strobes for the single cycle
// in which the count sits on its last value, marking the end of a bit period.
//   clk      : system clock, rising edge
//   reset    : synchronous, active-high; count returns to 0
//   clear    : synchronous clear, holds the count at 0 while high
//   bit_done : one-cycle strobe on the final cycle of each bit period
module uart_baud_counter #(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic bit_done
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (count == LAST) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

  assign bit_done = !clear && (count == LAST);

endmodule

// File: rtl/fifo_uart_tx.sv
// Drain stage for an 8-bit synchronous FIFO: pops one byte whenever the FIFO
// is non-empty and enabled, then sends it as an 8N1 UART frame, LSB first.
// Only one byte is in flight at a time.
//   clk        : system clock, rising edge
//   reset      : synchronous, active-high
//   en         : transmit enable, only looked at in IDLE
//   fifo_empty : FIFO empty flag
//   fifo_data  : FIFO registered read data (valid the cycle after the pop)
//   fifo_rd_en : FIFO read enable, one-cycle registered pulse per byte
//   tx         : serial line, idles high
//   busy       : high in every state except IDLE
module fifo_uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic       fifo_empty,
  input  logic [7:0] fifo_data,
  output logic       fifo_rd_en,
  output logic       tx,
  output logic       busy
);

  localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

  tx_state_t            state, state_next;
  logic [DATA_BITS-1:0] shift_q, shift_next;
  logic [2:0]           bit_idx, bit_idx_next;
  logic                 tx_q, tx_next;
  logic                 rd_q, rd_next;
  logic                 baud_clear;
  logic                 bit_done;

  // The bit timer only runs while a frame is on the line; in the pre-frame
  // states it is held cleared so START always gets a full bit period.
  assign baud_clear = (state == IDLE) || (state == REQ) || (state == WAIT);

  uart_baud_counter #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk      (clk),
    .reset    (reset),
    .clear    (baud_clear),
    .bit_done (bit_done)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      shift_q <= '0;
      bit_idx <= '0;
      tx_q    <= 1'b1;
      rd_q    <= 1'b0;
    end else begin
      state   <= state_next;
      shift_q <= shift_next;
      bit_idx <= bit_idx_next;
      tx_q    <= tx_next;
      rd_q    <= rd_next;
    end
  end

  always_comb begin
    state_next   = state;
    shift_next   = shift_q;
    bit_idx_next = bit_idx;
    tx_next      = tx_q;
    rd_next      = 1'b0;

    case (state)
      IDLE: begin
        tx_next = 1'b1;
        if (en && !fifo_empty) begin
          rd_next    = 1'b1;
          state_next = REQ;
        end
      end

      // FIFO pops on the edge leaving REQ; its registered data appears in WAIT.
      REQ: begin
        state_next = WAIT;
      end

      WAIT: begin
        shift_next   = fifo_data;
        bit_idx_next = '0;
        tx_next      = 1'b0;
        state_next   = START;
      end

      START: begin
        if (bit_done) begin
          tx_next    = shift_q[0];
          state_next = DATA;
        end
      end

      // tx already carries shift_q[0]; on each boundary the register moves
      // right and the new LSB (old bit 1) goes straight onto the line.
      DATA: begin
        if (bit_done) begin
          if (bit_idx == LAST_BIT) begin
            tx_next    = 1'b1;
            state_next = STOP;
          end else begin
            shift_next   = shift_q >> 1;
            tx_next      = shift_q[1];
            bit_idx_next = bit_idx + 1'b1;
          end
        end
      end

      STOP: begin
        if (bit_done) begin
          state_next = IDLE;
        end
      end

      default: begin
        tx_next    = 1'b1;
        state_next = IDLE;
      end
    endcase
  end

  assign tx         = tx_q;
  assign fifo_rd_en = rd_q;
  assign busy       = (state != IDLE);

endmodule
